// File: rtl/entropy_conditioner.sv
// entropy_conditioner: synchronises and decimates a raw noise bit, debiases it with a von Neumann extractor
// and runs a repetition-count health test; `define ENTROPY_STATS_EN adds the emit_count output.
module entropy_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int REP_LIMIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        raw_in,
    input  logic        fault_clr,
    output logic        entropy,
    output logic        entropy_valid,
`ifdef ENTROPY_STATS_EN
    output logic [15:0] emit_count,
`endif
    output logic        fault
);
    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    typedef enum logic {IDLE, HAVE_FIRST} state_t;
    state_t state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] div_cnt;
    logic [RW-1:0] rep_cnt, rep_next;
    logic s_raw, strobe, first, last, have_last, trip, emit;
    assign s_raw  = sync[SYNC_STAGES-1];
    assign strobe = enable && div_cnt == DW'(SAMPLE_DIV - 1);
    always_comb begin
        rep_next   = (have_last && s_raw == last) ? (rep_cnt == RW'(REP_LIMIT) ? rep_cnt : rep_cnt + RW'(1)) : RW'(1);
        trip       = strobe && rep_next == RW'(REP_LIMIT);
        // a trip on the completing strobe outranks the emission
        emit       = strobe && state == HAVE_FIRST && s_raw != first && !fault && !trip && !fault_clr;
        state_next = (!enable || fault || fault_clr) ? IDLE :
                     strobe ? (state == IDLE ? HAVE_FIRST : IDLE) : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= '0;
            div_cnt       <= '0;
            state         <= IDLE;
            first         <= 1'b0;
            last          <= 1'b0;
            have_last     <= 1'b0;
            rep_cnt       <= '0;
            fault         <= 1'b0;
            entropy       <= 1'b0;
            entropy_valid <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], raw_in};
            div_cnt       <= (!enable || div_cnt == DW'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DW'(1);
            state         <= state_next;
            if (state == IDLE && strobe)
                first <= s_raw;
            if (fault_clr || !enable) begin
                rep_cnt   <= '0;
                have_last <= 1'b0;
            end else if (strobe) begin
                rep_cnt   <= rep_next;
                last      <= s_raw;
                have_last <= 1'b1;
            end
            fault         <= !fault_clr && (fault || trip);
            entropy       <= emit && first;
            entropy_valid <= emit;
        end
    end
`ifdef ENTROPY_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            emit_count <= '0;
        else if (entropy_valid && emit_count != 16'hFFFF)
            emit_count <= emit_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_entropy_conditioner.sv
// tb_entropy_conditioner: randomized stimulus checked cycle by cycle against a sample-level reference model.
module tb_entropy_conditioner;
    localparam int S = 2, DIV = 4, LIM = 16;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, raw_in = 1'b0, fault_clr = 1'b0;
    logic entropy, entropy_valid, fault;
    int checks = 0, failures = 0;
`ifdef ENTROPY_STATS_EN
    logic [15:0] emit_count;
`endif
    entropy_conditioner #(.SYNC_STAGES(S), .SAMPLE_DIV(DIV), .REP_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .enable(enable), .raw_in(raw_in), .fault_clr(fault_clr),
        .entropy(entropy), .entropy_valid(entropy_valid),
`ifdef ENTROPY_STATS_EN
        .emit_count(emit_count),
`endif
        .fault(fault)
    );
    always #5 clk = ~clk;
    // model state: delay line of raw samples, phase in the sample period, pending first bit (-1 none),
    // length of the current run of identical samples and its value (-1 none)
    int pipe[$];
    int phase, pend, run, last_s, count;
    bit m_fault, m_valid, m_ent;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic model(input bit r, input bit e, input bit x, input bit c);
        int s, nrun;
        bit was_fault, strobe, trip;
        if (r) begin
            pipe = {};
            repeat (S) pipe.push_back(0);
            phase = 0; pend = -1; run = 0; last_s = -1; count = 0;
            m_fault = 0; m_valid = 0; m_ent = 0;
            return;
        end
        if (m_valid && count < 65535) count++;
        s = pipe[S-1];
        pipe.push_front(int'(x));
        void'(pipe.pop_back());
        strobe = e && phase == DIV - 1;
        was_fault = m_fault;
        m_valid = 0; m_ent = 0;
        if (!e) begin
            phase = 0; pend = -1; run = 0; last_s = -1;
            if (c) m_fault = 0;
            return;
        end
        phase = (phase + 1) % DIV;
        nrun = (last_s == s) ? (run < LIM ? run + 1 : LIM) : 1;
        trip = strobe && nrun == LIM;
        if (c) begin
            m_fault = 0; run = 0; last_s = -1; pend = -1;
            return;
        end
        if (strobe) begin
            run = nrun;
            last_s = s;
        end
        if (was_fault) pend = -1;
        else if (strobe) begin
            if (pend < 0) pend = s;
            else begin
                if (pend != s && !trip) begin
                    m_valid = 1;
                    m_ent = pend[0];
                end
                pend = -1;
            end
        end
        m_fault = was_fault || trip;
    endtask
    task automatic step(input bit r, input bit e, input bit x, input bit c);
        rst = r; enable = e; raw_in = x; fault_clr = c;
        @(posedge clk);
        model(r, e, x, c);
        @(negedge clk);
        check("entropy", entropy, m_ent);
        check("entropy_valid", entropy_valid, m_valid);
        check("fault", fault, m_fault);
`ifdef ENTROPY_STATS_EN
        check("emit_count", emit_count, count);
`endif
    endtask
    initial begin
        bit x, e;
        int hold;
        step(1, 0, 0, 0);
        check("reset_outputs", {entropy, entropy_valid, fault}, 3'b000);
        repeat (80) step(0, 1, 1, 0);
        check("held_one_fault", fault, 1);
        for (int i = 0; i < 32; i++) step(0, 1, (i / DIV) % 2 == 0, 0);
        check("no_emit_in_fault", entropy_valid, 0);
        step(0, 1, 0, 1);
        check("fault_cleared", fault, 0);
        for (int i = 0; i < 64; i++) step(0, 1, (i / DIV) % 2 == 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        check("mid_pair_reset", {entropy, entropy_valid, fault}, 3'b000);
        for (int i = 0; i < 40; i++) step(0, 1, (i / DIV) % 2 == 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, (i / DIV) % 2 == 1, 0);
`ifdef ENTROPY_STATS_EN
        @(negedge clk);
        force dut.emit_count = 16'hFFFE;
        @(posedge clk);
        release dut.emit_count;
        model(0, enable, raw_in, 0);
        count = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 64; i++) step(0, 1, (i / DIV) % 2 == 0, 0);
        check("emit_count_sat", emit_count, 16'hFFFF);
`endif
        x = 0; e = 1; hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                x = $urandom_range(0, 1);
                hold = ($urandom_range(0, 19) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) e = ~e;
            else if (!e && $urandom_range(0, 3) == 0) e = 1;
            step($urandom_range(0, 499) == 0, e, x, m_fault ? $urandom_range(0, 29) == 0 : $urandom_range(0, 299) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/entropy_conditioner.md
Name: entropy_conditioner

Overview:
- Sits directly upstream of the PRNG wrapper and drives its single-bit `entropy` input.
- Takes a raw, possibly asynchronous noise bit from a pad or ring oscillator, synchronises it, and decimates it to a fixed sample rate.
- Removes bias with a von Neumann pair extractor and runs a repetition-count health test.
- Drives `entropy` high only for a one-cycle pulse carrying a debiased 1. The PRNG XORs `entropy` into its state, so 0 is the neutral value.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on raw_in (minimum 2)
SAMPLE_DIV, 4, sample strobe period in clk cycles (minimum 1; 1 = sample every cycle)
REP_LIMIT, 16, count of consecutive identical samples that trips the health fault (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  conditioner run enable
raw_in  input  1  raw noise bit, asynchronous to clk
fault_clr  input  1  one-cycle pulse; clears the sticky health fault
entropy  output  1  debiased bit to the PRNG; 0 when no bit is emitted
entropy_valid  output  1  high for one cycle when a debiased bit is emitted
fault  output  1  sticky repetition-test failure flag

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high (rst, sampled on the rising edge of clk).
- Reset values: entropy=0, entropy_valid=0, fault=0. Internally: synchroniser flops=0, div_cnt=0, pair FSM=IDLE, rep_cnt=0, have_last=0.
- Synchroniser: raw_in passes through SYNC_STAGES flops; the last stage is s_raw.
- Divider:
  - With enable=1, div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - strobe = enable & (div_cnt == SAMPLE_DIV-1).
  - With enable=0, div_cnt is held at 0 and no strobe occurs.
- Pair FSM, IDLE and HAVE_FIRST; state advances only on strobe:
  - IDLE: latch first=s_raw, then go to HAVE_FIRST.
  - HAVE_FIRST:
    - s_raw != first: emit first. Pair 10 emits 1, pair 01 emits 0.
    - Pairs 00 and 11 are discarded.
    - Return to IDLE in all cases.
- Emission: registered. entropy_valid=1 and entropy=first in the cycle after the second strobe; both return to 0 on the next cycle. A debiased 0 gives entropy_valid=1, entropy=0.
- Repetition test, on each strobe:
  - If have_last and s_raw == last: rep_cnt = rep_cnt+1, saturating at REP_LIMIT.
  - Otherwise: rep_cnt = 1.
  - In both cases last=s_raw and have_last=1.
  - rep_cnt width is clog2(REP_LIMIT+1).
- Fault:
  - fault sets (registered) on the cycle after rep_cnt reaches REP_LIMIT and stays set.
  - While fault=1: no emission (entropy=0, entropy_valid=0) and the pair FSM is forced to IDLE. Strobes continue to update last and rep_cnt.
- fault_clr:
  - Clears fault, zeroes rep_cnt and have_last, and forces the FSM to IDLE.
  - If fault_clr and a new trip occur in the same cycle, fault_clr wins; the test restarts from rep_cnt=0.
- enable deasserted: FSM to IDLE with any held first bit discarded; rep_cnt and have_last cleared; fault retained. No emission while enable=0.
- Emission and trip on the same strobe: the trip wins. If the strobe that completes a differing pair also drives rep_cnt to REP_LIMIT, the bit is suppressed. This can only happen when REP_LIMIT is reached with value first, so it is unreachable for REP_LIMIT >= 2; keep the priority anyway.
- Reset mid-operation returns every register to its reset value in the same edge; any pending pair is lost.
- Latency from a raw_in change to the sample: SYNC_STAGES cycles plus up to SAMPLE_DIV-1 cycles of strobe alignment.

Optional Feature:
- Macro name: ENTROPY_STATS_EN.
- Defined:
  - Adds output port `emit_count` [15:0].
  - Counts emitted bits (entropy_valid pulses), saturating at 16'hFFFF.
  - Cleared only by rst; reset value 0.
- Undefined: the port and counter are absent, and the rest of the block is identical.

Test Plan:
- Alternating samples: enable=1, SAMPLE_DIV=4, raw_in driven 0,1,0,1,... aligned to strobes -> one entropy_valid pulse every 8 cycles with entropy=0; fault stays 0.
- Pattern 1,0 repeated -> pulse every 8 cycles with entropy=1. Pattern 1,1,0,0 repeated -> no pulses at all.
- raw_in held at 1 for 16 strobes -> fault=1 one cycle after the 16th strobe; no entropy_valid afterwards even when raw_in then alternates. A fault_clr pulse then lets alternating input resume emission after 2 strobes.
- Reset mid-pair: first bit latched, rst=1 for one cycle before the second strobe -> all outputs 0 the next cycle; the following pair is extracted correctly from a fresh IDLE.
- enable toggle: deassert between the first and second strobe of a pair, then reassert -> the held bit is discarded, no pulse from the split pair, and fault is unchanged.
- With ENTROPY_STATS_EN: 5 emitted bits -> emit_count=5; preload near saturation by forcing the counter -> it holds at 16'hFFFF.
